fwd_hazard_ctrl: RTL

Pipeline hazard and forwarding controller for the 5-stage core. It tracks destination-register tags of instructions in EX, MEM and WB, and generates the registered forwarding controls consumed by the execute stage (forward_XX_A/B, forward_XM_A/B, forward_XX_sel, forward_XM_sel). It detects load-use hazards and raises a one-cycle decode stall, inserting a bubble into EX. It also squashes tags on a taken branch or jump.

---
 rtl/fwd_pkg.sv | 31 +++
 rtl/fwd_stage_reg.sv | 29 ++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
// Holds the result-source encodings, the per-stage destination tag and the
// producer-match helper used by the top level.
package fwd_pkg;

  // Register-specifier width carried inside a stage tag.
  localparam int REG_W = 3;

  // Where the producing instruction's result comes from.
  localparam logic [1:0] WR_SRC_SPEC = 2'b00;
  localparam logic [1:0] WR_SRC_PC   = 2'b01;
  localparam logic [1:0] WR_SRC_MEM  = 2'b10;
  localparam logic [1:0] WR_SRC_ALU  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic [1:0]       wr_src;
  } tag_t;

  // Empty slot: not valid, writes nothing.
  localparam tag_t BUBBLE = tag_t'('0);

  // A stage produces the value a source operand needs.
  function automatic logic tag_match(input tag_t t, input logic [REG_W-1:0] src,
                                     input logic used);
    return t.valid & t.wr_en & used & (t.wr_reg == src);
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline tag register.
//   clk, rst   : clock, synchronous active-high reset (clears to BUBBLE)
//   i_en       : advance enable (low while memory stalls the pipe)
//   i_bubble   : load BUBBLE instead of i_d when advancing
//   i_d / o_q  : incoming tag / held tag
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_bubble,
  input  tag_t i_d,
  output tag_t o_q
);

  tag_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= BUBBLE;
    end else if (i_en) begin
      r_q <= i_bubble ? BUBBLE : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage core.
// Tracks destination tags in EX, MEM and WB and produces registered operand
// forwarding selects for the execute stage plus a combinational decode stall.
//   clk, rst                  : clock, synchronous active-high reset
//   id_*                      : decode-stage instruction description
//   flush                     : taken branch/jump resolved in EX
//   mem_stall                 : freeze the whole pipeline
//   stall                     : hold PC and IF/ID, bubble into EX
//   forward_XX_A/B, _sel      : take operand from EX/MEM, source type
//   forward_XM_A/B, _sel      : take operand from MEM/WB, source type
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_BITS = REG_W  // must match the tag width in fwd_pkg
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wr_reg,
  input  logic [1:0]          id_wr_src,
  input  logic                flush,
  input  logic                mem_stall,
  output logic                stall,
  output logic                forward_XX_A,
  output logic                forward_XX_B,
  output logic                forward_XM_A,
  output logic                forward_XM_B,
  output logic [1:0]          forward_XX_sel,
  output logic [1:0]          forward_XM_sel
);

  // Index 0 = EX, 1 = MEM, 2 = WB.
  tag_t w_stage_d [3];
  tag_t w_stage_q [3];
  tag_t w_id_tag;
  tag_t w_ex;
  tag_t w_mem;

  logic w_xx_a, w_xx_b, w_xm_a, w_xm_b;
  logic w_load_use, w_stall, w_accept;

  logic       r_fwd_xx_a, r_fwd_xx_b, r_fwd_xm_a, r_fwd_xm_b;
  logic [1:0] r_xx_sel, r_xm_sel;

  assign w_id_tag = '{valid: id_valid, wr_en: id_wr_en, wr_reg: id_wr_reg, wr_src: id_wr_src};
  assign w_ex     = w_stage_q[0];
  assign w_mem    = w_stage_q[1];

  // The younger (EX) producer wins; XM is only raised when XX is not.
  assign w_xx_a = id_valid & tag_match(w_ex, id_rs, id_rs_used);
  assign w_xx_b = id_valid & tag_match(w_ex, id_rt, id_rt_used);
  assign w_xm_a = id_valid & tag_match(w_mem, id_rs, id_rs_used) & ~w_xx_a;
  assign w_xm_b = id_valid & tag_match(w_mem, id_rt, id_rt_used) & ~w_xx_b;

  // Load data is not available on the EX/MEM path yet; wait one cycle for XM.
  assign w_load_use = (w_xx_a | w_xx_b) & (w_ex.wr_src == WR_SRC_MEM);
  assign w_stall    = w_load_use & ~flush;
  assign stall      = w_stall;

  // Decode instruction actually enters EX this cycle.
  assign w_accept = id_valid & ~w_stall & ~flush;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      if (gi == 0) begin : g_ex
        assign w_stage_d[gi] = w_id_tag;
      end else begin : g_later
        assign w_stage_d[gi] = w_stage_q[gi-1];
      end

      fwd_stage_reg u_stage (
        .clk      (clk),
        .rst      (rst),
        .i_en     (~mem_stall),
        .i_bubble ((gi == 0) ? ~w_accept : 1'b0),
        .i_d      (w_stage_d[gi]),
        .o_q      (w_stage_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_xx_a <= 1'b0;
      r_fwd_xx_b <= 1'b0;
      r_fwd_xm_a <= 1'b0;
      r_fwd_xm_b <= 1'b0;
      r_xx_sel   <= WR_SRC_SPEC;
      r_xm_sel   <= WR_SRC_SPEC;
    end else if (!mem_stall) begin
      r_fwd_xx_a <= w_accept & w_xx_a;
      r_fwd_xx_b <= w_accept & w_xx_b;
      r_fwd_xm_a <= w_accept & w_xm_a;
      r_fwd_xm_b <= w_accept & w_xm_b;
      // Each sel bus comes from a single stage, so A and B can share it.
      r_xx_sel   <= (w_accept & (w_xx_a | w_xx_b)) ? w_ex.wr_src  : WR_SRC_SPEC;
      r_xm_sel   <= (w_accept & (w_xm_a | w_xm_b)) ? w_mem.wr_src : WR_SRC_SPEC;
    end
  end

  assign forward_XX_A   = r_fwd_xx_a;
  assign forward_XX_B   = r_fwd_xx_b;
  assign forward_XM_A   = r_fwd_xm_a;
  assign forward_XM_B   = r_fwd_xm_b;
  assign forward_XX_sel = r_xx_sel;
  assign forward_XM_sel = r_xm_sel;

  // The WB entry is kept for debug: it must always trail MEM by one advance.
  a_wb_follows_mem: assert property (@(posedge clk) disable iff (rst)
    !mem_stall |=> (w_stage_q[2] == $past(w_stage_q[1])));

endmodule
